// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // srcA is read as two's complement for these operations
  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // srcB is read as two's complement for these operations
  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add (multiply) or
// restoring shift-subtract (divide). acc_hi is the upper product half or
// the partial remainder; acc_lo is the multiplier being shifted out or the
// quotient being shifted in.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             q_bit;

  // compute both step flavours and pick one by mode
  always_comb begin
    sum     = acc_hi + {1'b0, (acc_lo[0] ? operand : {WIDTH{1'b0}})};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {2'b00, operand};
    q_bit   = ~diff[WIDTH+1];
    if (is_div) begin
      hi_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
      lo_next = {acc_lo[WIDTH-2:0], q_bit};
    end else begin
      hi_next = {1'b0, sum[WIDTH:1]};
      lo_next = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for start; latches operands or takes the divide fast path
// CALC   | one shift-add / shift-subtract step per cycle, cnt counts down
// FIX    | sign correction and result select into res
// DONE   | done pulse, res/flag valid
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             flag
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t             state, state_nx;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     hi, hi_nx;
  logic [WIDTH-1:0]   lo, lo_nx;
  logic [WIDTH-1:0]   opnd;

  logic               a_neg, b_neg, res_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div_zero, div_ovf, fast;
  logic [WIDTH-1:0]   fast_res;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_q[2]),
    .acc_hi  (hi),
    .acc_lo  (lo),
    .operand (opnd),
    .hi_next (hi_nx),
    .lo_next (lo_nx)
  );

  // operand magnitudes, result sign and fast-path detection for the issue cycle
  always_comb begin
    a_neg    = a_is_signed(operation) & srcA[WIDTH-1];
    b_neg    = b_is_signed(operation) & srcB[WIDTH-1];
    mag_a    = a_neg ? -srcA : srcA;
    mag_b    = b_neg ? -srcB : srcB;
    // remainder follows the dividend; everything else follows the operand signs
    res_neg  = (operation[2] & operation[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = (srcB == {WIDTH{1'b0}});
    div_ovf  = ((operation == OP_DIV) || (operation == OP_REM)) &&
               (srcA == MOST_NEG) && (srcB == ALL_ONES);
    fast     = operation[2] & (div_zero | div_ovf);
    if (div_zero) fast_res = operation[1] ? srcA : ALL_ONES;
    else          fast_res = operation[1] ? {WIDTH{1'b0}} : srcA;
  end

  // sign correction and result selection for FIX
  always_comb begin
    prod     = {hi[WIDTH-1:0], lo};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -lo : lo;
    rem_fix  = neg_q ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fix_res = quot_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = fast ? S_DONE : S_CALC;
      S_CALC: if (cnt == '0) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // datapath: operand capture, iteration, and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_MUL;
      neg_q <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      res   <= '0;
      flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= operation;
            neg_q <= res_neg;
            if (fast) begin
              res  <= fast_res;
              flag <= 1'b1;
            end else begin
              cnt  <= CW'(WIDTH - 1);
              hi   <= '0;
              // divide shifts the dividend out of lo; multiply shifts the multiplier out
              lo   <= operation[2] ? mag_a : mag_b;
              opnd <= operation[2] ? mag_b : mag_a;
            end
          end
        end
        S_CALC: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          res  <= fix_res;
          flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32: table vectors, random ops against an
// arithmetic model, and hand-written handshake/reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int LAT_NORM = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   operation;
  logic [W-1:0] srcA, srcB;
  logic         busy, done, flag;
  logic [W-1:0] res;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         flag;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         flag;
    int           lat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operation (operation),
    .srcA      (srcA),
    .srcB      (srcB),
    .busy      (busy),
    .done      (done),
    .res       (res),
    .flag      (flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, output logic fl);
    logic signed [63:0] sa, sbv, p;
    logic [63:0] up;
    logic [W-1:0] r;
    fl  = 1'b0;
    sa  = 64'($signed(a));
    sbv = 64'($signed(b));
    up  = {32'b0, a} * {32'b0, b};
    r   = '0;
    case (op)
      OP_MUL:    r = up[31:0];
      OP_MULH:   begin p = sa * sbv; r = p[63:32]; end
      OP_MULHSU: begin p = sa * $signed({32'b0, b}); r = p[63:32]; end
      OP_MULHU:  r = up[63:32];
      OP_DIV, OP_REM: begin
        if (b == 0) begin
          fl = 1'b1;
          r  = (op == OP_DIV) ? 32'hFFFF_FFFF : a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          fl = 1'b1;
          r  = (op == OP_DIV) ? a : 32'h0;
        end else begin
          p = (op == OP_DIV) ? (sa / sbv) : (sa % sbv);
          r = p[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          fl = 1'b1;
          r  = (op == OP_DIVU) ? 32'hFFFF_FFFF : a;
        end else begin
          r = (op == OP_DIVU) ? (a / b) : (a % b);
        end
      end
    endcase
    return r;
  endfunction

  // drive a start pulse at the next negedge and push the expectation; returns just after edge E
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ef, input int el);
    exp_t e;
    @(negedge clk);
    operation = op; srcA = a; srcB = b; start = 1'b1;
    e.res = er; e.flag = ef; e.lat = el;
    sb.push_back(e);
    @(posedge clk);
  endtask

  // wait for done (bounded), optionally pulse a stray start at cycle pulse_at, then compare
  task automatic collect(input string name, input int pulse_at);
    int n;
    logic busy_ok;
    exp_t e;
    n = 0;
    busy_ok = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (n == pulse_at) begin
        start = 1'b1; operation = OP_DIV; srcA = 32'd5; srcB = 32'd0;
      end
      if (n == pulse_at + 1) start = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
    end
    if (!done) check({name, " timeout"}, 64'(done), 64'd1);
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({name, " res"}, 64'(res), 64'(e.res));
      check({name, " flag"}, 64'(flag), 64'(e.flag));
      check({name, " latency"}, 64'(n), 64'(e.lat));
      check({name, " busy"}, 64'(busy_ok), 64'd1);
    end
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb, rr;
    logic         rf;
    int           seen;

    tbl.push_back('{OP_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, LAT_NORM});
    tbl.push_back('{OP_MULH,   32'h80000000,  32'h80000000, 32'h40000000, 1'b0, LAT_NORM});
    tbl.push_back('{OP_MULHU,  32'h80000000,  32'h80000000, 32'h40000000, 1'b0, LAT_NORM});
    tbl.push_back('{OP_MULHSU, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 1'b0, LAT_NORM});
    tbl.push_back('{OP_DIVU,   32'd1025,      32'd1000,     32'd1,        1'b0, LAT_NORM});
    tbl.push_back('{OP_REMU,   32'd1025,      32'd1000,     32'd25,       1'b0, LAT_NORM});
    tbl.push_back('{OP_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0, LAT_NORM});
    tbl.push_back('{OP_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0, LAT_NORM});
    tbl.push_back('{OP_DIV,    32'd513,       32'd0,        32'hFFFFFFFF, 1'b1, 1});
    tbl.push_back('{OP_REMU,   32'd513,       32'd0,        32'd513,      1'b1, 1});
    tbl.push_back('{OP_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1, 1});
    tbl.push_back('{OP_REM,    32'h80000000,  32'hFFFFFFFF, 32'd0,        1'b1, 1});
    tbl.push_back('{OP_DIVU,   32'h80000000,  32'hFFFFFFFF, 32'd0,        1'b0, LAT_NORM});
    tbl.push_back('{OP_MUL,    32'd0,         32'd5,        32'd0,        1'b0, LAT_NORM});
    tbl.push_back('{OP_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, LAT_NORM});
    tbl.push_back('{OP_MULH,   32'h7FFFFFFF,  32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0, LAT_NORM});
    tbl.push_back('{OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, LAT_NORM});
    tbl.push_back('{OP_REM,    32'd7,         32'hFFFFFFFE, 32'd1,        1'b0, LAT_NORM});
    tbl.push_back('{OP_DIV,    32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, LAT_NORM});
    tbl.push_back('{OP_DIVU,   32'd7,         32'd0,        32'hFFFFFFFF, 1'b1, 1});
    tbl.push_back('{OP_REM,    32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9, 1'b1, 1});

    rst = 1'b1; start = 1'b0; operation = OP_MUL; srcA = '0; srcB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset res",  64'(res),  64'd0);
    check("reset flag", 64'(flag), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].flag, tbl[i].lat);
      collect($sformatf("vec%0d", i), -1);
    end

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 4 == 0) rb = '0;
      if (i % 7 == 3) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if (i % 5 == 1) rb = 32'($urandom_range(1, 100));
      rr = model(rop, ra, rb, rf);
      issue(rop, ra, rb, rr, rf, (rop[2] && rf) ? 1 : LAT_NORM);
      collect($sformatf("rand%0d op%0d", i, rop), -1);
    end

    // a start pulse mid-operation must be ignored
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, LAT_NORM);
    collect("ignored start", 10);

    // reset during CALC abandons the operation
    @(negedge clk);
    operation = OP_MUL; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-calc busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort res",  64'(res),  64'd0);
    check("abort flag", 64'(flag), 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort no done", 64'(seen), 64'd0);

    // back-to-back: start raised in the DONE cycle and held into IDLE
    issue(OP_DIVU, 32'd1025, 32'd1000, 32'd1, 1'b0, LAT_NORM);
    collect("b2b first", -1);
    operation = OP_MUL; srcA = 32'd7; srcB = 32'hFFFFFFFD; start = 1'b1;
    begin
      exp_t e;
      e.res = 32'hFFFFFFEB; e.flag = 1'b0; e.lat = LAT_NORM;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check("b2b idle busy", 64'(busy), 64'd0);
    check("b2b idle done", 64'(done), 64'd0);
    @(posedge clk);
    collect("b2b second", -1);

    check("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
